aes_key_expand: RTL

Parametrised successor of the AES-128 round-key generator. Expands a 128-, 192- or 256-bit cipher key, selected per operation, into Nr+1 128-bit round keys (11, 13 or 15). Keys are produced one 32-bit word per clock. Each completed round key is streamed to the round-key store with a write strobe and address. The block sits between the key-load path of the AES control FSM and the round-key RAM/register file used by the cipher core.

---
 rtl/aes_key_expand.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// AES round-key generator for 128/192/256-bit keys. One expanded word per
// clock; each completed 128-bit round key is strobed out with its index.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by
// the standard affine transform.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t3, t7, t15, t31, t63, t127;
    t3   = gf_mul(gf_mul(x, x), x);
    t7   = gf_mul(gf_mul(t3, t3), x);
    t15  = gf_mul(gf_mul(t7, t7), x);
    t31  = gf_mul(gf_mul(t15, t15), x);
    t63  = gf_mul(gf_mul(t31, t31), x);
    t127 = gf_mul(gf_mul(t63, t63), x);
    return gf_mul(t127, t127);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Pure combinational lookup.
  always_comb out_o = affine(gf_inv(in_i));

endmodule

module aes_key_expand #(
  parameter int MAX_KEY_S = 256,
  parameter int RK_ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             key_len,
  input  logic [0:MAX_KEY_S-1]   key,
  output logic                   busy,
  output logic [0:127]           round_key,
  output logic [0:RK_ADDR_W-1]   round_key_addr,
  output logic                   w_e,
  output logic                   en_o
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  state_t                 state_q, state_d;
  logic [0:MAX_KEY_S-1]   key_q;
  logic [2:0]             nkm1_q;     // Nk-1: 3, 5 or 7
  logic [5:0]             last_q;     // index of the final word: 43, 51 or 59
  logic [5:0]             i_q;        // word index
  logic [2:0]             imod_q;     // i mod Nk, kept as a wrap counter
  logic [7:0]             rcon_q;
  logic [31:0]            win_q [8];  // win_q[k] holds w[i-1-k]
  logic                   busy_q, w_e_q, en_o_q;
  logic [0:127]           rk_q;
  logic [RK_ADDR_W-1:0]   rk_addr_q;

  logic                   start;
  logic                   key_phase;
  logic [31:0]            temp, sub_in, sub_out, w_new;

  assign start = (state_q == IDLE) && en && (key_len != 2'b11);

  // Four byte-wide S-boxes form SubWord.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.in_i(sub_in[8*b +: 8]), .out_o(sub_out[8*b +: 8]));
  end

  // Next expanded word from the window and the current position within Nk.
  always_comb begin
    key_phase = (i_q <= {3'b000, nkm1_q});
    temp      = win_q[0];
    sub_in    = (imod_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    if (key_phase)
      w_new = key_q[{i_q[2:0], 5'b00000} +: 32];
    else if (imod_q == 3'd0)
      w_new = win_q[nkm1_q] ^ sub_out ^ {rcon_q, 24'h000000};
    else if (nkm1_q == 3'd7 && imod_q == 3'd4)
      w_new = win_q[nkm1_q] ^ sub_out;
    else
      w_new = win_q[nkm1_q] ^ temp;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: key_len 11 never leaves IDLE; en is ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GEN;
      GEN:     if (i_q == last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, Rcon, mode latch and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      nkm1_q    <= '0;
      last_q    <= '0;
      i_q       <= '0;
      imod_q    <= '0;
      rcon_q    <= '0;
      busy_q    <= 1'b0;
      w_e_q     <= 1'b0;
      en_o_q    <= 1'b0;
      rk_q      <= '0;
      rk_addr_q <= '0;
    end else begin
      w_e_q  <= 1'b0;
      en_o_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          case (key_len)
            2'b00:   begin nkm1_q <= 3'd3; last_q <= 6'd43; end
            2'b01:   begin nkm1_q <= 3'd5; last_q <= 6'd51; end
            default: begin nkm1_q <= 3'd7; last_q <= 6'd59; end
          endcase
          i_q    <= '0;
          imod_q <= '0;
          rcon_q <= 8'h01;
          busy_q <= 1'b1;
        end
        GEN: begin
          i_q    <= i_q + 6'd1;
          imod_q <= (imod_q == nkm1_q) ? 3'd0 : imod_q + 3'd1;
          if (!key_phase && imod_q == 3'd0) rcon_q <= xtime(rcon_q);
          // The window already holds w[i-3..i-1], so it doubles as the
          // round-key accumulator; the boundary ignores Nk entirely.
          if (i_q[1:0] == 2'd3) begin
            rk_q      <= {win_q[2], win_q[1], win_q[0], w_new};
            rk_addr_q <= RK_ADDR_W'(i_q[5:2]);
            w_e_q     <= 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          en_o_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Key latch and word window: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (start) key_q <= key;
    if (state_q == GEN) begin
      win_q[0] <= w_new;
      for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
    end
  end

  assign busy           = busy_q;
  assign w_e            = w_e_q;
  assign en_o           = en_o_q;
  assign round_key      = rk_q;
  assign round_key_addr = rk_addr_q;

endmodule
